// File: rtl/sd_cmd_arbiter.sv
// sd_cmd_arbiter
//   Shares the single SD/SPI command path (CRC-prepare stage + SPI manager)
//   between NREQ requesters using round-robin arbitration. Only one command is
//   in flight at a time. The winning requester's command is issued to the
//   prepare stage as a start/start40 pulse. The arbiter then waits for the
//   manager's completion strobe and returns the R1 response byte to that
//   requester.
//
// Parameters
//   NREQ         number of requesters (2..8)
//   TIMEOUT_CYC  WAIT cycles allowed before the command is aborted
//                (only used when SDCMD_TIMEOUT_EN is defined)
//   CW           timeout counter width, 2**CW > TIMEOUT_CYC
//
// Optional feature
//   SDCMD_TIMEOUT_EN   when defined, WAIT is bounded by TIMEOUT_CYC cycles.
//                      On expiry, done pulses with resp=8'hFF and err=1.
//                      When undefined, WAIT lasts until cmd_done and err is 0.
//
// Ports
//   dclk, rst        clock, asynchronous active-high reset
//   req[NREQ]        per-requester request, held until its done pulse
//   req_cmd/arg      packed per-requester command index (6b) / argument (32b)
//   req_long         1 = long-response command (start40)
//   req_readit       1 = command is followed by a data-block read
//   gnt[NREQ]        one-hot grant, high from ISSUE through DONE
//   done[NREQ]       one-cycle completion pulse to the granted requester
//   resp, err        response byte and timeout flag, valid with done
//   start, start40   one-cycle issue pulse to the prepare stage
//   cmd, arg, readit command fields, stable from ISSUE until the next grant
//   cmd_done         manager completion strobe (sampled in WAIT only)
//   cmd_resp         manager response byte, valid with cmd_done
module sd_cmd_arbiter #(
  parameter int NREQ        = 3,
  parameter int TIMEOUT_CYC = 65535,
  parameter int CW          = 16
) (
  input  logic               dclk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [6*NREQ-1:0]  req_cmd,
  input  logic [32*NREQ-1:0] req_arg,
  input  logic [NREQ-1:0]    req_long,
  input  logic [NREQ-1:0]    req_readit,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic [7:0]         resp,
  output logic               err,
  output logic               start,
  output logic               start40,
  output logic [5:0]         cmd,
  output logic [31:0]        arg,
  output logic               readit,
  input  logic               cmd_done,
  input  logic [7:0]         cmd_resp
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   win_q, win_d;
  // Highest-priority requester for the next arbitration (last winner + 1).
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [5:0]      cmd_q, cmd_d;
  logic [31:0]     arg_q, arg_d;
  logic            readit_q, readit_d;
  logic            long_q, long_d;
  logic [7:0]      resp_q, resp_d;
  logic            err_q, err_d;
  logic [IW-1:0]   pick;

`ifdef SDCMD_TIMEOUT_EN
  logic [CW-1:0]   tmo_q, tmo_d;
`else
  localparam int   UNUSED_CFG = TIMEOUT_CYC + CW;
`endif

  // First asserted request, scanning upward from ptr with wrap-around.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   p);
    logic [IW-1:0] sel;
    logic          found;
    int            idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      if (!found && r[idx]) begin
        sel   = IW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  assign pick = rr_pick(req, ptr_q);

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    win_d    = win_q;
    ptr_d    = ptr_q;
    cmd_d    = cmd_q;
    arg_d    = arg_q;
    readit_d = readit_q;
    long_d   = long_q;
    resp_d   = resp_q;
    err_d    = err_q;
`ifdef SDCMD_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          win_d    = pick;
          gnt_d    = NREQ'(1) << pick;
          cmd_d    = req_cmd[6*int'(pick) +: 6];
          arg_d    = req_arg[32*int'(pick) +: 32];
          readit_d = req_readit[pick];
          long_d   = req_long[pick];
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef SDCMD_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the same cycle as expiry takes precedence.
        if (cmd_done) begin
          resp_d  = cmd_resp;
          err_d   = 1'b0;
          state_d = S_DONE;
        end
`ifdef SDCMD_TIMEOUT_EN
        else if (tmo_q == CW'(TIMEOUT_CYC - 1)) begin
          resp_d  = 8'hFF;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + CW'(1);
        end
`endif
      end
      S_DONE: begin
        gnt_d   = '0;
        ptr_d   = (win_q == IW'(NREQ - 1)) ? '0 : win_q + IW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      win_q    <= '0;
      ptr_q    <= '0;
      cmd_q    <= '0;
      arg_q    <= '0;
      readit_q <= 1'b0;
      long_q   <= 1'b0;
      resp_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      win_q    <= win_d;
      ptr_q    <= ptr_d;
      cmd_q    <= cmd_d;
      arg_q    <= arg_d;
      readit_q <= readit_d;
      long_q   <= long_d;
      resp_q   <= resp_d;
      err_q    <= err_d;
    end
  end

`ifdef SDCMD_TIMEOUT_EN
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
  assign err = err_q;
`else
  // err_q is never set without the timeout; the port is tied low.
  logic unused_err;
  assign unused_err = err_q;
  assign err = 1'b0;
`endif

  assign gnt     = gnt_q;
  assign done    = (state_q == S_DONE) ? gnt_q : '0;
  assign resp    = resp_q;
  assign start   = (state_q == S_ISSUE) && !long_q;
  assign start40 = (state_q == S_ISSUE) && long_q;
  assign cmd     = cmd_q;
  assign arg     = arg_q;
  assign readit  = readit_q;

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
module tb_sd_cmd_arbiter;
  localparam int NREQ = 3;

  logic               dclk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req;
  logic [6*NREQ-1:0]  req_cmd;
  logic [32*NREQ-1:0] req_arg;
  logic [NREQ-1:0]    req_long;
  logic [NREQ-1:0]    req_readit;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [7:0]         resp;
  logic               err;
  logic               start;
  logic               start40;
  logic [5:0]         cmd;
  logic [31:0]        arg;
  logic               readit;
  logic               cmd_done;
  logic [7:0]         cmd_resp;

  int total = 0;
  int bad   = 0;
  int n_start = 0, n_start40 = 0, n_both = 0, n_done = 0;
  int b_start, b_start40, b_done;

  sd_cmd_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(10), .CW(16)) dut (
    .dclk(dclk), .rst(rst), .req(req), .req_cmd(req_cmd), .req_arg(req_arg),
    .req_long(req_long), .req_readit(req_readit), .gnt(gnt), .done(done),
    .resp(resp), .err(err), .start(start), .start40(start40), .cmd(cmd),
    .arg(arg), .readit(readit), .cmd_done(cmd_done), .cmd_resp(cmd_resp)
  );

  always #5 dclk = ~dclk;

  // Pulse monitors: values read at posedge are those of the cycle just ending.
  always @(posedge dclk) begin
    if (start)          n_start++;
    if (start40)        n_start40++;
    if (start && start40) n_both++;
    if (|done)          n_done++;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Called on the ISSUE negedge; strobes cmd_done on WAIT cycle wcyc,
  // returns on the DONE negedge.
  task automatic serve(input int wcyc, input logic [7:0] r);
    repeat (wcyc) @(negedge dclk);
    cmd_done = 1'b1;
    cmd_resp = r;
    @(negedge dclk);
    cmd_done = 1'b0;
    cmd_resp = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [NREQ-1:0] exp_g [4];
    rst = 1'b1; req = '0; req_cmd = '0; req_arg = '0; req_long = '0;
    req_readit = '0; cmd_done = 1'b0; cmd_resp = 8'h00;
    repeat (3) @(negedge dclk);
    check_val("rst_gnt",  64'(gnt), 64'(0));
    check_val("rst_done", 64'(done), 64'(0));
    check_val("rst_start", 64'({start, start40}), 64'(0));
    check_val("rst_cmd",  64'({cmd, arg, readit}), 64'(0));
    check_val("rst_resp", 64'({resp, err}), 64'(0));
    rst = 1'b0;
    @(negedge dclk);

    // Single read command from requester 1; other slices hold decoys.
    req_cmd    = {6'd33, 6'd17, 6'd5};
    req_arg    = {32'hDEAD_0002, 32'h0000_0200, 32'hDEAD_0000};
    req_readit = 3'b010;
    req        = 3'b010;
    b_start = n_start; b_start40 = n_start40;
    @(negedge dclk);
    check_val("t1_gnt", 64'(gnt), 64'(3'b010));
    check_val("t1_start", 64'({start, start40}), 64'(2'b10));
    check_val("t1_cmd", 64'(cmd), 64'(17));
    check_val("t1_arg", 64'(arg), 64'(32'h200));
    check_val("t1_readit", 64'(readit), 64'(1));
    @(negedge dclk);
    check_val("t1_start_once", 64'(start), 64'(0));
    check_val("t1_nodone_wait", 64'(done), 64'(0));
    serve(2, 8'h00);
    check_val("t1_done", 64'(done), 64'(3'b010));
    check_val("t1_resp", 64'({resp, err}), 64'({8'h00, 1'b0}));
    req = '0;
    @(negedge dclk);
    check_val("t1_gnt_clr", 64'({gnt, done}), 64'(0));
    check_val("t1_pulses", 64'({n_start - b_start, n_start40 - b_start40}), 64'({32'd1, 32'd0}));

    // Long-response command from requester 0.
    req_cmd = {6'd33, 6'd17, 6'd8};
    req_arg = {32'hDEAD_0002, 32'h0000_0200, 32'h0000_01AA};
    req_long = 3'b001; req_readit = '0; req = 3'b001;
    b_start = n_start; b_start40 = n_start40;
    @(negedge dclk);
    check_val("t2_gnt", 64'(gnt), 64'(3'b001));
    check_val("t2_start", 64'({start, start40}), 64'(2'b01));
    check_val("t2_cmd", 64'({cmd, arg}), 64'({6'd8, 32'h1AA}));
    serve(1, 8'h01);
    check_val("t2_done", 64'(done), 64'(3'b001));
    check_val("t2_resp", 64'(resp), 64'(8'h01));
    req = '0; req_long = '0;
    @(negedge dclk);
    check_val("t2_pulses", 64'({n_start - b_start, n_start40 - b_start40}), 64'({32'd0, 32'd1}));

    // cmd_done in IDLE (no request), then held through IDLE->ISSUE.
    cmd_done = 1'b1; cmd_resp = 8'h77;
    @(negedge dclk);
    check_val("t3_idle_strobe", 64'({gnt, done}), 64'(0));
    req = 3'b100;
    @(negedge dclk);
    check_val("t3_issue_gnt", 64'(gnt), 64'(3'b100));
    check_val("t3_issue_done", 64'(done), 64'(0));
    @(negedge dclk);
    cmd_done = 1'b0; cmd_resp = 8'h00;
    check_val("t3_wait1_done", 64'(done), 64'(0));
    @(negedge dclk);
    check_val("t3_wait2", 64'({gnt, done}), 64'({3'b100, 3'b000}));
    cmd_done = 1'b1; cmd_resp = 8'h22;
    @(negedge dclk);
    cmd_done = 1'b0; cmd_resp = 8'h00;
    check_val("t3_done", 64'(done), 64'(3'b100));
    check_val("t3_resp", 64'(resp), 64'(8'h22));
    req = '0;
    @(negedge dclk);

    // All three requesting permanently: round-robin order 0,1,2,0.
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    req_cmd = {6'd12, 6'd11, 6'd10};
    req = 3'b111;
    b_start = n_start; b_start40 = n_start40;
    for (int i = 0; i < 4; i++) begin
      @(negedge dclk);
      check_val($sformatf("t4_gnt%0d", i), 64'(gnt), 64'(exp_g[i]));
      check_val($sformatf("t4_cmd%0d", i), 64'(cmd), 64'(i == 1 ? 11 : (i == 2 ? 12 : 10)));
      serve(2, 8'(8'h40 + i));
      check_val($sformatf("t4_done%0d", i), 64'(done), 64'(exp_g[i]));
      @(negedge dclk);
    end
    req = '0;
    check_val("t4_pulses", 64'({n_start - b_start, n_start40 - b_start40}), 64'({32'd4, 32'd0}));

    // Reset during WAIT, then arbitration restarts at requester 0.
    req = 3'b010;
    @(negedge dclk);
    @(negedge dclk);
    b_done = n_done;
    rst = 1'b1; req = '0;
    #1;
    check_val("t5_rst_gnt", 64'({gnt, done}), 64'(0));
    check_val("t5_rst_out", 64'({cmd, arg, readit, start, start40}), 64'(0));
    check_val("t5_rst_resp", 64'({resp, err}), 64'(0));
    @(negedge dclk);
    rst = 1'b0;
    repeat (3) @(negedge dclk);
    check_val("t5_no_done", 64'(n_done - b_done), 64'(0));
    req = 3'b011;
    @(negedge dclk);
    check_val("t5_rr_restart", 64'(gnt), 64'(3'b001));
    serve(1, 8'h5A);
    check_val("t5_done", 64'({done, resp}), 64'({3'b001, 8'h5A}));
    req = '0;
    @(negedge dclk);

    // Requester withdraws mid-command; command still completes (ptr=1 -> 1 idle, so 2).
    req = 3'b100;
    @(negedge dclk);
    check_val("t6_gnt", 64'(gnt), 64'(3'b100));
    req = '0;
    serve(2, 8'h05);
    check_val("t6_done", 64'({done, resp}), 64'({3'b100, 8'h05}));
    @(negedge dclk);

`ifdef SDCMD_TIMEOUT_EN
    // No cmd_done: abort after 10 WAIT cycles.
    req = 3'b001;
    @(negedge dclk);
    check_val("t7_gnt", 64'(gnt), 64'(3'b001));
    req = '0;
    repeat (10) @(negedge dclk);
    check_val("t7_wait10", 64'(done), 64'(0));
    @(negedge dclk);
    check_val("t7_done", 64'(done), 64'(3'b001));
    check_val("t7_resp", 64'({resp, err}), 64'({8'hFF, 1'b1}));
    @(negedge dclk);
`else
    // No timeout: WAIT persists well past 10 cycles until cmd_done.
    req = 3'b001;
    @(negedge dclk);
    check_val("t7_gnt", 64'(gnt), 64'(3'b001));
    req = '0;
    repeat (20) @(negedge dclk);
    check_val("t7_still_wait", 64'({gnt, done}), 64'({3'b001, 3'b000}));
    cmd_done = 1'b1; cmd_resp = 8'h3C;
    @(negedge dclk);
    cmd_done = 1'b0; cmd_resp = 8'h00;
    check_val("t7_done", 64'(done), 64'(3'b001));
    check_val("t7_resp", 64'({resp, err}), 64'({8'h3C, 1'b0}));
    @(negedge dclk);
`endif

    check_val("never_both_starts", 64'(n_both), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
